// File: rtl/button_events_pkg.sv
// button_events_pkg: shared state encoding, default timing constants and helpers
package button_events_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_e;

    localparam int DefSize            = 3;
    localparam int DefClockPeriod_ns  = 20;
    localparam int DefTick_ns         = 1_000_000;
    localparam int DefLongPress_ticks = 1000;
    localparam int DefRepeat_ticks    = 200;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/button_events_tick_gen.sv
// tick_gen: timebase prescaler, one-cycle Tick every Div clocks
//   Clock : system clock
//   Reset : synchronous active-high reset, clears the prescaler
//   Tick  : one-cycle pulse every Div clocks, constant 1 when Div <= 1
module tick_gen #(
    parameter int Div = 50_000
) (
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);
    if (Div <= 1) begin : g_always
        logic unused_clk_rst;
        assign unused_clk_rst = Clock ^ Reset;
        assign Tick = 1'b1;
    end else begin : g_div
        localparam int W = $clog2(Div);
        localparam logic [W-1:0] Last = W'(Div - 1);
        logic [W-1:0] cnt_q;
        always_ff @(posedge Clock) begin
            if (Reset) cnt_q <= '0;
            else       cnt_q <= (cnt_q == Last) ? '0 : cnt_q + W'(1);
        end
        assign Tick = (cnt_q == Last);
    end
endmodule

// File: rtl/button_events.sv
// button_events: per-channel press / release / long-press event generator
//   Clock     : system clock, all logic on its rising edge
//   Reset     : synchronous active-high reset
//   I         : debounced button levels, active-low (0 = pressed)
//   Press     : one-cycle pulse per press (and per auto-repeat)
//   Release   : one-cycle pulse when a pressed button is released
//   LongPress : one-cycle pulse when the hold reaches LongPress_ticks
//   Held      : high while the channel is PRESSED or LONG
// Define BUTTON_EVENTS_AUTOREPEAT_EN to pulse Press every Repeat_ticks while LONG.
module button_events
    import button_events_pkg::*;
#(
    parameter int Size            = DefSize,
    parameter int ClockPeriod_ns  = DefClockPeriod_ns,
    parameter int Tick_ns         = DefTick_ns,
    parameter int LongPress_ticks = DefLongPress_ticks,
    parameter int Repeat_ticks    = DefRepeat_ticks
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [Size-1:0] I,
    output logic [Size-1:0] Press,
    output logic [Size-1:0] Release,
    output logic [Size-1:0] LongPress,
    output logic [Size-1:0] Held
);
    localparam int CntW = $clog2(max_int(LongPress_ticks, Repeat_ticks) + 1);
    localparam logic [CntW-1:0] LongCnt = CntW'(LongPress_ticks);
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam logic [CntW-1:0] RepCnt = CntW'(Repeat_ticks);
`endif

    logic            tick;
    logic [Size-1:0] prev_q;

    tick_gen #(.Div(Tick_ns / ClockPeriod_ns)) u_tick (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (tick)
    );

    // Prev resets to released so a button held through reset yields a press.
    always_ff @(posedge Clock) begin
        if (Reset) prev_q <= '1;
        else       prev_q <= I;
    end

    for (genvar c = 0; c < Size; c++) begin : g_ch
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
        logic            press_q, press_d, rel_q, rel_d, long_q, long_d, held_q;
        logic            fall, rise;
        assign fall    = prev_q[c] & ~I[c];
        assign rise    = ~prev_q[c] & I[c];
        assign cnt_inc = cnt_q + CntW'(1);
        // Release is checked before the tick so it wins over a coinciding threshold.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                IDLE: if (fall) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
                PRESSED: if (rise) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else if (tick) begin
                    state_d = (cnt_inc == LongCnt) ? LONG : PRESSED;
                    long_d  = (cnt_inc == LongCnt);
                    cnt_d   = (cnt_inc == LongCnt) ? '0 : cnt_inc;
                end
                LONG: if (rise) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                end else if (tick) begin
                    press_d = (cnt_inc == RepCnt);
                    cnt_d   = (cnt_inc == RepCnt) ? '0 : cnt_inc;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        always_ff @(posedge Clock) begin
            if (Reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                held_q  <= (state_d != IDLE);
            end
        end
        assign Press[c]     = press_q;
        assign Release[c]   = rel_q;
        assign LongPress[c] = long_q;
        assign Held[c]      = held_q;
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: scoreboard bench for button_events
module tb_button_events;
    localparam int Size = 3, ClkNs = 20, TickNs = 100, LP = 4, RP = 2;
    localparam int TickClks = TickNs / ClkNs;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int Never = 32'h7fff_ffff;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [Size-1:0] I = '1;
    logic [Size-1:0] Press, Release, LongPress, Held;

    button_events #(
        .Size(Size), .ClockPeriod_ns(ClkNs), .Tick_ns(TickNs),
        .LongPress_ticks(LP), .Repeat_ticks(RP)
    ) dut (
        .Clock(Clock), .Reset(Reset), .I(I),
        .Press(Press), .Release(Release), .LongPress(LongPress), .Held(Held)
    );

    always #10 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] v;
    } ent_t;
    ent_t sb[$];
    ent_t e_mon;

    int vectors = 0, miscompares = 0;
    int rst_cyc = 0;
    int pe[Size], re[Size];
    int t3;

    task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got P/R/L/H=%b required=%b", tag, cyc, got, exp);
        end
    endtask

    function automatic bit tick_at(input int c);
        return c > rst_cyc && (c - rst_cyc) % TickClks == 0;
    endfunction

    function automatic int nth_tick(input int p, input int k);
        int t, n;
        t = p;
        n = 0;
        while (n < k) begin
            t++;
            if (tick_at(t)) n++;
        end
        return t;
    endfunction

    function automatic int next_tick(input int c);
        int t;
        t = c;
        while (!tick_at(t)) t++;
        return t;
    endfunction

    // Expected outputs after edge c from each channel's press/release edges.
    function automatic logic [11:0] model(input int c);
        logic [Size-1:0] p, r, l, h;
        int k;
        p = '0; r = '0; l = '0; h = '0;
        for (int i = 0; i < Size; i++) begin
            if (c == re[i] && re[i] > pe[i]) r[i] = 1'b1;
            if (c >= pe[i] && c < re[i]) begin
                h[i] = 1'b1;
                k = 0;
                for (int t = pe[i] + 1; t <= c; t++) if (tick_at(t)) k++;
                if (c == pe[i]) p[i] = 1'b1;
                else if (tick_at(c) && k == LP) l[i] = 1'b1;
                else if (AR && tick_at(c) && k > LP && (k - LP) % RP == 0) p[i] = 1'b1;
            end
        end
        return {p, r, l, h};
    endfunction

    always @(negedge Clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_mon = sb.pop_front();
            check_vec(e_mon.tag, {Press, Release, LongPress, Held}, e_mon.v);
        end
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < Size; i++) begin
            pe[i] = -1;
            re[i] = -1;
        end
    endtask

    task automatic push(input int from, input int to, input string tag);
        ent_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = c;
            e.tag = tag;
            e.v   = model(c);
            sb.push_back(e);
        end
    endtask

    task automatic run(input int to, input string tag);
        push(cyc + 1, to, tag);
        while (cyc < to) begin
            for (int i = 0; i < Size; i++) I[i] = !(cyc + 1 >= pe[i] && cyc + 1 < re[i]);
            step();
        end
    endtask

    initial begin
        clear();
        push(1, 3, "reset");
        while (cyc < 3) step();
        Reset = 1'b0;
        rst_cyc = cyc;

        clear();
        pe[0] = cyc + 2;
        re[0] = pe[0] + 3;
        run(re[0] + 3, "short");

        clear();
        pe[1] = cyc + 2;
        re[1] = pe[1] + 40;
        run(re[1] + 2, "long_hold");

        clear();
        pe[2] = next_tick(cyc + 2);
        re[2] = nth_tick(pe[2], LP);
        run(re[2] + 2, "rel_at_thr");

        clear();
        for (int i = 0; i < Size; i++) pe[i] = cyc + 2;
        re[0] = pe[0] + 2;
        re[1] = pe[0] + 5;
        re[2] = pe[0] + 9;
        run(pe[0] + 12, "all_ch");

        clear();
        pe[0] = cyc + 2;
        re[0] = Never;
        t3 = nth_tick(pe[0], 3);
        run(t3, "pre_rst");
        Reset = 1'b1;
        clear();
        push(cyc + 1, cyc + 2, "in_rst");
        step();
        step();
        Reset = 1'b0;
        rst_cyc = cyc;
        pe[0] = cyc + 1;
        re[0] = nth_tick(pe[0], LP) + 3;
        run(re[0] + 3, "post_rst");

        step();
        check_vec("sb_drain", 12'(sb.size()), 12'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
